// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the execute-stage ALU.
//   alu_op_e  - ALUControl encoding (00=ADD 01=SUB 10=AND 11=ORR)
//   FLAG_*    - bit positions of N/Z/C/V inside ALUFlags
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational WIDTH-bit adder/subtractor with carry and overflow.
// Ports:
//   a, b  in  WIDTH  operands
//   sub   in  1      0: a+b, 1: a-b (computed as a + ~b + 1)
//   sum   out WIDTH  result modulo 2^WIDTH
//   cout  out 1      carry out of bit WIDTH-1 (for SUB, 1 means no borrow)
//   ovf   out 1      signed overflow
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   wide;

  // Subtraction reuses the adder: invert b and inject the +1 as carry-in.
  assign b_eff = sub ? ~b : b;
  assign wide  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum   = wide[WIDTH-1:0];
  assign cout  = wide[WIDTH];
  // Overflow: both addends share a sign and the result sign differs from it.
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// alu: registered 32-bit integer ALU for the execute stage.
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   SrcA, SrcB  in   WIDTH  operands
//   ALUControl  in   2      00=ADD 01=SUB 10=AND 11=ORR
//   ALUResult   out  WIDTH  registered result
//   ALUFlags    out  4      registered {N,Z,C,V}
//   OvfSticky   out  1      present only when ALU_OVF_STICKY_EN is defined;
//                           set on any capture with V=1, cleared only by reset
// Timing: inputs sampled on edge k are visible on the outputs after edge k.
// There is no handshake: a new operation is accepted on every edge.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [1:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
`ifdef ALU_OVF_STICKY_EN
  output logic [3:0]       ALUFlags,
  output logic             OvfSticky
`else
  output logic [3:0]       ALUFlags
`endif
);

  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_ovf;
  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             v_d;
  logic [3:0]       flags_d;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (SrcA),
    .b    (SrcB),
    .sub  (ALUControl == ALU_SUB),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (ALUControl)
      ALU_ADD, ALU_SUB: begin
        res_d = as_sum;
        c_d   = as_cout;
        v_d   = as_ovf;
      end
      ALU_AND: res_d = SrcA & SrcB;
      ALU_ORR: res_d = SrcA | SrcB;
      // Only reachable with an unknown control value; keeps the next state clean.
      default: res_d = '0;
    endcase
  end

  always_comb begin
    flags_d         = 4'b0000;
    flags_d[FLAG_N] = res_d[WIDTH-1];
    flags_d[FLAG_Z] = (res_d == '0);
    flags_d[FLAG_C] = c_d;
    flags_d[FLAG_V] = v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResult <= '0;
      ALUFlags  <= 4'b0000;
    end else begin
      ALUResult <= res_d;
      ALUFlags  <= flags_d;
    end
  end

`ifdef ALU_OVF_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OvfSticky <= 1'b0;
    end else if (flags_d[FLAG_V]) begin
      OvfSticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of alu against a reference model
// computed with wide integer arithmetic. Optional OvfSticky is checked when
// ALU_OVF_STICKY_EN is defined.
module tb_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [1:0]   ALUControl;
  logic [W-1:0] ALUResult;
  logic [3:0]   ALUFlags;
`ifdef ALU_OVF_STICKY_EN
  logic         OvfSticky;
  logic         sticky_exp;
`endif

  int tests_run;
  int tests_failed;

  // Expected {N,Z,C,V,result} for each operation in flight.
  logic [35:0] exp_q[$];
  logic [35:0] last_exp;

  alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .ALUResult  (ALUResult),
`ifdef ALU_OVF_STICKY_EN
    .ALUFlags   (ALUFlags),
    .OvfSticky  (OvfSticky)
`else
    .ALUFlags   (ALUFlags)
`endif
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain signed/unsigned 64-bit arithmetic.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    longint ua, ub, sa, sb, r_u, r_s;
    logic [31:0] res;
    logic c, v;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 32'd0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: begin
        r_u = ua + ub;
        r_s = sa + sb;
        res = r_u[31:0];
        c   = (r_u > 64'sd4294967295);
        v   = (r_s > 64'sd2147483647) || (r_s < -64'sd2147483648);
      end
      2'b01: begin
        r_s = sa - sb;
        res = a - b;
        c   = (ua >= ub);
        v   = (r_s > 64'sd2147483647) || (r_s < -64'sd2147483648);
      end
      2'b10: res = a & b;
      default: res = a | b;
    endcase
    return {res[31], (res == 32'd0), c, v, res};
  endfunction

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed flags=%b result=%h, expected flags=%b result=%h",
             tag, obs[35:32], obs[31:0], exp[35:32], exp[31:0]);
    end
  endtask

  // Driver: apply inputs mid-cycle, confirm outputs still hold the previous
  // result, then check the new result one edge later.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input string tag);
    logic [35:0] e;
    SrcA = a; SrcB = b; ALUControl = op;
    exp_q.push_back(model(a, b, op));
    #1;
    check({tag, "_hold"}, {ALUFlags, ALUResult}, last_exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    last_exp = e;
    check(tag, {ALUFlags, ALUResult}, e);
`ifdef ALU_OVF_STICKY_EN
    sticky_exp = sticky_exp | e[32];
    check({tag, "_sticky"}, {35'd0, OvfSticky}, {35'd0, sticky_exp});
`endif
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    last_exp = 36'd0;
`ifdef ALU_OVF_STICKY_EN
    sticky_exp = 1'b0;
`endif
    rst_n = 1'b0;
    SrcA = '0; SrcB = '0; ALUControl = 2'b00;
    #1;
    check("reset_initial", {ALUFlags, ALUResult}, 36'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, including spec examples and boundaries
    do_op(32'h0000000A, 32'h00000005, 2'b00, "add_basic");
    check("add_basic_lit", {ALUFlags, ALUResult}, {4'b0000, 32'h0000000F});
    do_op(32'h0000000A, 32'h00000005, 2'b01, "sub_basic");
    check("sub_basic_lit", {ALUFlags, ALUResult}, {4'b0010, 32'h00000005});
    do_op(32'h0000000A, 32'h00000005, 2'b10, "and_basic");
    check("and_basic_lit", {ALUFlags, ALUResult}, {4'b0100, 32'h00000000});
    do_op(32'h0000000A, 32'h00000005, 2'b11, "orr_basic");
    check("orr_basic_lit", {ALUFlags, ALUResult}, {4'b0000, 32'h0000000F});
    do_op(32'h7FFFFFFF, 32'h00000001, 2'b00, "add_ovf");
    check("add_ovf_lit", {ALUFlags, ALUResult}, {4'b1001, 32'h80000000});
    do_op(32'hFFFFFFFF, 32'h00000001, 2'b00, "add_wrap");
    check("add_wrap_lit", {ALUFlags, ALUResult}, {4'b0110, 32'h00000000});
    do_op(32'h00000000, 32'h00000001, 2'b01, "sub_borrow");
    check("sub_borrow_lit", {ALUFlags, ALUResult}, {4'b1000, 32'hFFFFFFFF});
    do_op(32'h80000000, 32'h00000001, 2'b01, "sub_ovf");
    check("sub_ovf_lit", {ALUFlags, ALUResult}, {4'b0011, 32'h7FFFFFFF});
    do_op(32'h12345678, 32'h12345678, 2'b01, "sub_equal");
    check("sub_equal_lit", {ALUFlags, ALUResult}, {4'b0110, 32'h00000000});

    // Randomized back-to-back operations
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 3))
        0: a = 32'h80000000 | (a & 32'h0000000F);
        1: b = (($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : a);
        default: ;
      endcase
      do_op(a, b, 2'($urandom_range(0, 3)), $sformatf("rand_%0d", i));
    end

    // Unknown control for one cycle, then a valid op must be clean
    SrcA = 32'h00000003; SrcB = 32'h00000004; ALUControl = 2'bxx;
    @(posedge clk);
    #1;
    last_exp = 36'd0;
    SrcA = 32'h00000003; SrcB = 32'h00000004; ALUControl = 2'b00;
    exp_q.push_back(model(32'h3, 32'h4, 2'b00));
    @(posedge clk);
    #1;
    last_exp = exp_q.pop_front();
    check("after_x_ctrl", {ALUFlags, ALUResult}, last_exp);

    // Make outputs nonzero, then assert reset mid-cycle with no clock edge
    do_op(32'h00000001, 32'h00000002, 2'b00, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", {ALUFlags, ALUResult}, 36'd0);
    last_exp = 36'd0;
`ifdef ALU_OVF_STICKY_EN
    sticky_exp = 1'b0;
    check("reset_sticky", {35'd0, OvfSticky}, 36'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'hFFFFFFF0, 32'h00000010, 2'b00, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
